// File: rtl/countones_sched.sv
// countones_sched: popcount engine shared by two requesters under round-robin arbitration.
// The accepted operand is counted CHUNK bits per cycle in a narrow adder, and the result is
// returned tagged with the requester id.
// Optional build macro: COUNTONES_SCHED_EARLY_EXIT_EN. When it is defined, counting stops as
// soon as the remaining shifted operand is all zeros. The count is the same in both builds.
module countones_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_id
);

    localparam int unsigned NBEATS = WIDTH / CHUNK;
    localparam int unsigned BW     = $clog2(NBEATS + 1);
    localparam int unsigned PW     = $clog2(CHUNK + 1);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    acc_q;
    logic [BW-1:0]    beats_q;
    logic             id_q;
    logic             prio_q;
    logic             out_valid_q;

    logic             grant;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic [PW-1:0]    beat_cnt;
    logic [WIDTH-1:0] sr_shift;
    logic             count_last;

    // Arbitrate: prio_q breaks the tie when both are valid, otherwise the lone requester wins
    always_comb begin
        grant_valid = in0_valid | in1_valid;
        if (in0_valid && in1_valid) begin
            grant = prio_q;
        end else begin
            grant = in1_valid;
        end
    end

    assign in0_ready  = (state_q == StIdle) && grant_valid && !grant;
    assign in1_ready  = (state_q == StIdle) && grant_valid && grant;
    assign grant_data = grant ? in1_data : in0_data;

    // Popcount of the low chunk of the shift register
    always_comb begin
        beat_cnt = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            beat_cnt = beat_cnt + PW'(sr_q[i]);
        end
    end

    assign sr_shift = sr_q >> CHUNK;

`ifdef COUNTONES_SCHED_EARLY_EXIT_EN
    // Nothing left to count once the post-shift operand is all zeros
    assign count_last = (beats_q == BW'(1)) || (sr_shift == '0);
`else
    assign count_last = (beats_q == BW'(1));
`endif

    // FSM with datapath and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            acc_q       <= '0;
            beats_q     <= '0;
            id_q        <= 1'b0;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        sr_q    <= grant_data;
                        acc_q   <= '0;
                        beats_q <= BW'(NBEATS);
                        id_q    <= grant;
                        prio_q  <= ~grant;
                        state_q <= StCount;
                    end
                end
                StCount: begin
                    acc_q   <= acc_q + CW'(beat_cnt);
                    sr_q    <= sr_shift;
                    beats_q <= beats_q - BW'(1);
                    if (count_last) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    // Result is handed off and the FSM returns to idle; no accept this cycle
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = acc_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_countones_sched.sv
// Directed bench for countones_sched: a 32/8 instance and an 8/1 instance share clock and reset.
module tb_countones_sched;

`ifdef COUNTONES_SCHED_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in0_data = '0, in1_data = '0;
    logic        in0_ready, in1_ready, out_valid, out_id;
    logic [5:0]  out_count;

    logic        b_in0_valid = 1'b0, b_in1_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0]  b_in0_data = '0, b_in1_data = '0;
    logic        b_in0_ready, b_in1_ready, b_out_valid, b_out_id;
    logic [3:0]  b_out_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    countones_sched #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_id    (out_id)
    );

    countones_sched #(.WIDTH(8), .CHUNK(1)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (b_in0_valid),
        .in0_ready (b_in0_ready),
        .in0_data  (b_in0_data),
        .in1_valid (b_in1_valid),
        .in1_ready (b_in1_ready),
        .in1_data  (b_in1_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_count (b_out_count),
        .out_id    (b_out_id)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // who: 0/1 = that requester got ready, 2 = both (illegal), -1 = none within budget
    task automatic wait_ready(input bit sel, output int who);
        logic r0, r1;
        who = -1;
        for (int k = 0; k < 20 && who < 0; k++) begin
            @(negedge clk);
            r0 = sel ? b_in0_ready : in0_ready;
            r1 = sel ? b_in1_ready : in1_ready;
            if (r0 && r1) who = 2;
            else if (r0) who = 0;
            else if (r1) who = 1;
        end
    endtask

    // Call just after the accept edge; lat = edges after accept until out_valid, -1 on timeout
    task automatic wait_valid(input bit sel, output int lat);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick();
            if (sel ? b_out_valid : out_valid) lat = k;
        end
    endtask

    function automatic int ones8(input logic [7:0] d);
        int c = 0;
        for (int i = 0; i < 8; i++) if (d[i]) c++;
        return c;
    endfunction

    function automatic int lat8(input logic [7:0] d);
        int l = 1;
        for (int i = 0; i < 8; i++) if (d[i]) l = i + 1;
        return EARLY ? l : 8;
    endfunction

    task automatic test_reset;
        tick(); tick();
        n_checks++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in0_ready: got %b want 0", in0_ready); end
        n_checks++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in1_ready: got %b want 0", in1_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_count !== 6'd0) begin n_fail++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
        n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL rst_out_id: got %b want 0", out_id); end
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_out_valid: got %b want 0", b_out_valid); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        int who, lat;
        in0_data = 32'hFFFF_FFFF; in0_valid = 1'b1; out_ready = 1'b1;
        wait_ready(1'b0, who);
        n_checks++; if (who !== 0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", who); end
        tick(); in0_valid = 1'b0;
        wait_valid(1'b0, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", lat); end
        n_checks++; if (out_count !== 6'd32) begin n_fail++; $display("FAIL single_count: got %0d want 32", out_count); end
        n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL single_id: got %b want 0", out_id); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin;
        int r0 = 0, r1 = 0, both = 0, nres = 0, cyc = 0;
        int ids[4];
        int cnts[4];
        rst = 1'b1;
        in0_data = 32'h0000_000F; in1_data = 32'h8000_0001;
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
        tick(); tick(); rst = 1'b0;
        while (nres < 4 && cyc < 80) begin
            @(negedge clk); cyc++;
            if (in0_ready) r0++;
            if (in1_ready) r1++;
            if (in0_ready && in1_ready) both++;
            if (out_valid) begin ids[nres] = out_id; cnts[nres] = out_count; nres++; end
        end
        tick(); in0_valid = 1'b0; in1_valid = 1'b0;
        n_checks++; if (nres !== 4) begin n_fail++; $display("FAIL rr_results: got %0d want 4", nres); end
        for (int k = 0; k < nres; k++) begin
            n_checks++; if (ids[k] !== k % 2) begin n_fail++; $display("FAIL rr_id%0d: got %0d want %0d", k, ids[k], k % 2); end
            n_checks++; if (cnts[k] !== ((k % 2) ? 2 : 4)) begin n_fail++; $display("FAIL rr_count%0d: got %0d want %0d", k, cnts[k], (k % 2) ? 2 : 4); end
        end
        n_checks++; if (r0 !== 2) begin n_fail++; $display("FAIL rr_ready0_pulses: got %0d want 2", r0); end
        n_checks++; if (r1 !== 2) begin n_fail++; $display("FAIL rr_ready1_pulses: got %0d want 2", r1); end
        n_checks++; if (both !== 0) begin n_fail++; $display("FAIL rr_both_ready: got %0d want 0", both); end
    endtask

    task automatic test_stall;
        int who, lat;
        in0_data = 32'h0F0F_0F0F; in0_valid = 1'b1; out_ready = 1'b0;
        wait_ready(1'b0, who);
        n_checks++; if (who !== 0) begin n_fail++; $display("FAIL stall_grant: got %0d want 0", who); end
        tick(); in0_valid = 1'b0;
        wait_valid(1'b0, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL stall_latency: got %0d want 4", lat); end
        in0_valid = 1'b1; in1_valid = 1'b1; in1_data = 32'h0000_0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d: got %b want 1", k, out_valid); end
            n_checks++; if (out_count !== 6'd16) begin n_fail++; $display("FAIL stall_count%0d: got %0d want 16", k, out_count); end
            n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL stall_id%0d: got %b want 0", k, out_id); end
            n_checks++; if ({in0_ready, in1_ready} !== 2'b00) begin n_fail++; $display("FAIL stall_ready%0d: got %b want 00", k, {in0_ready, in1_ready}); end
        end
        tick(); out_ready = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_before_handoff: got %b want 1", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_handoff: got %b want 0", out_valid); end
    endtask

    task automatic test_early_exit;
        int who, lat;
        logic [31:0] vec [2];
        int          cnt [2];
        vec[0] = 32'h0000_0003; cnt[0] = 2;
        vec[1] = 32'h0000_0000; cnt[1] = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in0_data = vec[k]; in0_valid = 1'b1;
            wait_ready(1'b0, who);
            tick(); in0_valid = 1'b0;
            wait_valid(1'b0, lat);
            n_checks++; if (lat !== (EARLY ? 1 : 4)) begin n_fail++; $display("FAIL early_latency%0d: got %0d want %0d", k, lat, EARLY ? 1 : 4); end
            n_checks++; if (out_count !== 6'(cnt[k])) begin n_fail++; $display("FAIL early_count%0d: got %0d want %0d", k, out_count, cnt[k]); end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        int who, lat;
        in0_data = 32'hFF00_00FF; in0_valid = 1'b1; out_ready = 1'b1;
        wait_ready(1'b0, who);
        tick(); in0_valid = 1'b0;
        tick();
        // Now inside the second COUNT cycle with acc already holding 8
        rst = 1'b1; #1;
        n_checks++; if (out_count !== 6'd0) begin n_fail++; $display("FAIL rmid_acc_async: got %0d want 0", out_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_async: got %b want 0", out_valid); end
        tick(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost%0d: got %b want 0", k, out_valid); end
        end
        in0_data = 32'h0000_0007; in1_data = 32'h0000_0001; in0_valid = 1'b1; in1_valid = 1'b1;
        wait_ready(1'b0, who);
        n_checks++; if (who !== 0) begin n_fail++; $display("FAIL rmid_prio: got %0d want 0", who); end
        tick(); in0_valid = 1'b0; in1_valid = 1'b0;
        wait_valid(1'b0, lat);
        n_checks++; if (out_count !== 6'd3) begin n_fail++; $display("FAIL rmid_count: got %0d want 3", out_count); end
        n_checks++; if (out_id !== 1'b0) begin n_fail++; $display("FAIL rmid_id: got %b want 0", out_id); end
        tick();
    endtask

    task automatic test_narrow;
        int who, lat;
        b_in0_data = 8'hA5; b_in0_valid = 1'b1; b_out_ready = 1'b1;
        wait_ready(1'b1, who);
        tick(); b_in0_valid = 1'b0;
        wait_valid(1'b1, lat);
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL narrow_latency: got %0d want 8", lat); end
        n_checks++; if (b_out_count !== 4'd4) begin n_fail++; $display("FAIL narrow_count: got %0d want 4", b_out_count); end
        tick();
    endtask

    task automatic test_random;
        int who, lat, r, exp_cnt, exp_lat;
        logic [7:0] d;
        rst = 1'b1;
        b_in0_data = 8'($urandom); b_in1_data = 8'($urandom);
        b_in0_valid = 1'b1; b_in1_valid = 1'b1; b_out_ready = 1'b1;
        tick(); rst = 1'b0;
        for (int k = 0; k < 1000 && n_fail < 50; k++) begin
            r = k % 2;
            wait_ready(1'b1, who);
            n_checks++; if (who !== r) begin n_fail++; $display("FAIL rnd_grant%0d: got %0d want %0d", k, who, r); end
            d = r ? b_in1_data : b_in0_data;
            exp_cnt = ones8(d);
            exp_lat = lat8(d);
            tick();
            if (r == 1) b_in1_data = 8'($urandom); else b_in0_data = 8'($urandom);
            wait_valid(1'b1, lat);
            n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency%0d: got %0d want %0d", k, lat, exp_lat); end
            n_checks++; if (b_out_id !== 1'(r)) begin n_fail++; $display("FAIL rnd_id%0d: got %b want %0d", k, b_out_id, r); end
            n_checks++; if (b_out_count !== 4'(exp_cnt)) begin n_fail++; $display("FAIL rnd_count%0d: got %0d want %0d", k, b_out_count, exp_cnt); end
            n_checks++; if (b_out_count !== 4'($countones(d))) begin n_fail++; $display("FAIL rnd_countones%0d: got %0d want %0d", k, b_out_count, $countones(d)); end
        end
        b_in0_valid = 1'b0; b_in1_valid = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_early_exit();
        test_reset_mid();
        test_narrow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
